// File: rtl/jtopl_snd_tx_if.sv
// Sample-in / serial-out bundle for jtopl_snd_tx.
//   cen        bit-timing enable, one bclk half-period per asserted cycle
//   snd        sample word from the accumulator (two's complement)
//   snd_stb    one-cycle strobe qualifying snd
//   clr_flags  clears the sticky overrun/underrun flags
//   bclk/lrck/sdata  left-justified three-wire DAC link
//   busy       transmitter running
//   overrun/underrun sticky buffer status
interface jtopl_snd_tx_if #(parameter int DW = 16);
  logic          cen;
  logic [DW-1:0] snd;
  logic          snd_stb;
  logic          clr_flags;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic          busy;
  logic          overrun;
  logic          underrun;

  modport master (
    output cen, snd, snd_stb, clr_flags,
    input  bclk, lrck, sdata, busy, overrun, underrun
  );

  modport slave (
    input  cen, snd, snd_stb, clr_flags,
    output bclk, lrck, sdata, busy, overrun, underrun
  );
endinterface

// File: rtl/jtopl_snd_tx.sv
// Serial transmitter for the FM core's mono sample.
// A one-deep buffer takes the accumulator's strobed sample; each frame is
// shifted out MSB-first on a left-justified bclk/lrck/sdata link, with the
// same word in the left and right slots.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   bus         jtopl_snd_tx_if.slave (see interface header)
module jtopl_snd_tx #(
  parameter int DW    = 16,
  parameter int SLOTW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  jtopl_snd_tx_if.slave      bus
);

  localparam int CW = $clog2(2*SLOTW);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOTW);
  localparam logic [CW-1:0] LAST_C = CW'(2*SLOTW-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic [DW-1:0]    pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DW-1:0]    last_q, last_d;
  logic [SLOTW-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;

  logic             consume, load, ovr_ev, und_ev;
  logic [DW-1:0]    ld_src;
  logic [SLOTW-1:0] ld_word;

  always_comb begin
    state_d    = state_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    last_d     = last_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    consume    = 1'b0;
    load       = 1'b0;
    ovr_ev     = 1'b0;
    und_ev     = 1'b0;
    ld_src     = last_q;
    ld_word    = '0;

    case (state_q)
      IDLE: begin
        // bclk stays low on the load cycle; that cycle is the first half of bit 0
        if (bus.cen && pend_vld_q) begin
          state_d  = RUN;
          consume  = 1'b1;
          load     = 1'b1;
          ld_src   = pend_q;
          last_d   = pend_q;
          bitcnt_d = '0;
          lrck_d   = 1'b0;
          bclk_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.cen) begin
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            // falling edge: advance bit, change data/lrck
            bitcnt_d = (bitcnt_q == LAST_C) ? '0 : bitcnt_q + CW'(1);
            lrck_d   = (bitcnt_d >= SLOT_C);
            if (bitcnt_d == SLOT_C) begin
              load = 1'b1;              // right slot repeats the left word
            end else if (bitcnt_d == '0) begin
              load = 1'b1;
              if (pend_vld_q) begin
                ld_src  = pend_q;
                last_d  = pend_q;
                consume = 1'b1;
              end else begin
                und_ev  = 1'b1;         // no fresh sample: resend last word
              end
            end else begin
              shreg_d = shreg_q << 1;
              sdata_d = shreg_q[SLOTW-2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // left-justified: sample in the top bits, zero padding below
    ld_word[SLOTW-1 -: DW] = ld_src;
    if (load) begin
      shreg_d = ld_word;
      sdata_d = ld_word[SLOTW-1];
    end

    // capture; a load in the same cycle takes the old pend first
    if (bus.snd_stb) begin
      pend_d     = bus.snd;
      pend_vld_d = 1'b1;
      ovr_ev     = pend_vld_q & ~consume;
    end else if (consume) begin
      pend_vld_d = 1'b0;
    end

    overrun_d  = ovr_ev | (overrun_q  & ~bus.clr_flags);
    underrun_d = und_ev | (underrun_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      last_q     <= '0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      last_q     <= last_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
    end
  end

  assign bus.bclk     = bclk_q;
  assign bus.lrck     = lrck_q;
  assign bus.sdata    = sdata_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_jtopl_snd_tx.sv
// Bench for jtopl_snd_tx: frame-level reference model checked every cycle,
// a serial decoder for the received words, and directed scenarios.
module tb_jtopl_snd_tx;
  localparam int DW    = 16;
  localparam int SLOTW = 16;
  localparam int FR    = 4*SLOTW;   // cen cycles per frame

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtopl_snd_tx_if #(.DW(DW)) bus();
  jtopl_snd_tx #(.DW(DW), .SLOTW(SLOTW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cen3  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model (frame arithmetic) ----------------
  bit          m_run, m_pvld, m_ovr, m_und;
  int          m_k;               // index of the last cen cycle since the run began
  logic [15:0] m_pend, m_word;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_pvld = 0; m_ovr = 0; m_und = 0; m_k = 0;
      m_pend = '0; m_word = '0;
    end else begin
      bit cons, eo, eu;
      cons = 0; eo = 0; eu = 0;
      if (bus.cen) begin
        if (!m_run) begin
          if (m_pvld) begin m_run = 1; m_k = 0; m_word = m_pend; cons = 1; end
        end else begin
          m_k++;
          if (m_k % FR == 0) begin
            if (m_pvld) begin m_word = m_pend; cons = 1; end
            else eu = 1;
          end
        end
      end
      if (bus.snd_stb) begin
        eo = m_pvld && !cons;
        m_pend = bus.snd;
        m_pvld = 1;
      end else if (cons) m_pvld = 0;
      m_ovr = eo || (m_ovr && !bus.clr_flags);
      m_und = eu || (m_und && !bus.clr_flags);
    end
  end

  // compare DUT against the model on every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      logic eb, el, ed;
      int b;
      if (!m_run) begin
        eb = 0; el = 0; ed = 0;
      end else begin
        b  = (m_k / 2) % (2*SLOTW);
        eb = logic'(m_k % 2);
        el = (b >= SLOTW);
        ed = m_word[15 - (b % SLOTW)];
      end
      chk("bclk",     {31'd0, bus.bclk},     {31'd0, eb});
      chk("lrck",     {31'd0, bus.lrck},     {31'd0, el});
      chk("sdata",    {31'd0, bus.sdata},    {31'd0, ed});
      chk("busy",     {31'd0, bus.busy},     {31'd0, m_run});
      chk("overrun",  {31'd0, bus.overrun},  {31'd0, m_ovr});
      chk("underrun", {31'd0, bus.underrun}, {31'd0, m_und});
    end
  end

  // ---------------- serial decoder ----------------
  logic        pb;
  logic [31:0] sh;
  int          nb, last_rise, bclk_per;
  logic [31:0] dec_q[$];
  int          fr_start[$];

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      pb = 0; nb = 0; sh = '0;
    end else begin
      if (bus.bclk && !pb) begin
        if (nb == 0) fr_start.push_back(cyc);
        bclk_per  = cyc - last_rise;
        last_rise = cyc;
        sh = {sh[30:0], bus.sdata};
        nb++;
        if (nb == 2*SLOTW) begin dec_q.push_back(sh); nb = 0; end
      end
      pb = bus.bclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit stb = 0, input logic [15:0] v = 16'h0, input bit clr = 0);
    @(negedge clk); #1;
    bus.cen       = cen3 ? (cyc % 3 == 0) : 1'b1;
    bus.snd_stb   = stb;
    bus.snd       = stb ? v : 16'h0;
    bus.clr_flags = clr;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0;
    bus.snd_stb = 0; bus.snd = '0; bus.clr_flags = 0; bus.cen = 0;
    step(); step();
    dec_q.delete();
    fr_start.delete();
    rst_n = 1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (dec_q.size() < n && i < budget) begin step(); i++; end
    if (dec_q.size() < n) chk("frame_timeout", 32'(dec_q.size()), 32'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cen = 0; bus.snd = '0; bus.snd_stb = 0; bus.clr_flags = 0;

    // reset and idle
    do_reset();
    chk("reset_outs", {26'd0, bus.bclk, bus.lrck, bus.sdata, bus.busy, bus.overrun, bus.underrun}, 32'd0);
    repeat (100) step();
    chk("idle_outs", {26'd0, bus.bclk, bus.lrck, bus.sdata, bus.busy, bus.overrun, bus.underrun}, 32'd0);

    // single sample, then underrun repeat and flag clear
    do_reset();
    step(1, 16'hA5C3);
    step();
    chk("busy_before_load", {31'd0, bus.busy}, 32'd0);
    step();
    chk("load_outs", {28'd0, bus.busy, bus.bclk, bus.lrck, bus.sdata}, 32'b1001);
    wait_frames(2, 300);
    if (dec_q.size() >= 2) begin
      chk("a5c3_f0", dec_q[0], 32'hA5C3A5C3);
      chk("a5c3_f1", dec_q[1], 32'hA5C3A5C3);
      chk("frame_len", 32'(fr_start[1] - fr_start[0]), 32'd64);
    end
    chk("und_set", {31'd0, bus.underrun}, 32'd1);
    repeat (4) step();
    step(0, 16'h0, 1);
    step();
    chk("und_clr", {31'd0, bus.underrun}, 32'd0);
    wait_frames(3, 200);
    chk("und_still_clr", {31'd0, bus.underrun}, 32'd0);
    repeat (2) step();
    chk("und_reset", {31'd0, bus.underrun}, 32'd1);

    // back-to-back frames, one sample per frame
    do_reset();
    step(1, 16'h7FFF);
    repeat (63) step();
    step(1, 16'h8000);
    repeat (63) step();
    step(1, 16'h0001);
    wait_frames(3, 400);
    if (dec_q.size() >= 3) begin
      chk("seq_f0", dec_q[0], 32'h7FFF7FFF);
      chk("seq_f1", dec_q[1], 32'h80008000);
      chk("seq_f2", dec_q[2], 32'h00010001);
    end
    chk("seq_flags", {30'd0, bus.overrun, bus.underrun}, 32'd0);

    // overrun: second sample overwrites the first
    do_reset();
    step(1, 16'hAAAA);
    repeat (10) step();
    step(1, 16'h1111);
    repeat (4) step();
    step(1, 16'h2222);
    step();
    chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
    wait_frames(2, 200);
    if (dec_q.size() >= 2) begin
      chk("ovr_f0", dec_q[0], 32'hAAAAAAAA);
      chk("ovr_f1", dec_q[1], 32'h22222222);
    end

    // cen every third cycle, then async reset mid-frame
    cen3 = 1'b1;
    do_reset();
    step(1, 16'h5A3C);
    wait_frames(2, 700);
    if (dec_q.size() >= 2) begin
      chk("cen3_f0", dec_q[0], 32'h5A3C5A3C);
      chk("cen3_f1", dec_q[1], 32'h5A3C5A3C);
      chk("cen3_frame_len", 32'(fr_start[1] - fr_start[0]), 32'd192);
    end
    chk("cen3_bclk_per", 32'(bclk_per), 32'd6);
    repeat (40) step();
    chk("busy_mid", {31'd0, bus.busy}, 32'd1);
    @(negedge clk); #3;
    rst_n = 0;
    #1;
    chk("async_rst_outs", {26'd0, bus.bclk, bus.lrck, bus.sdata, bus.busy, bus.overrun, bus.underrun}, 32'd0);
    step();
    rst_n = 1;
    cen3 = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
